// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every requester-side and memory-side signal of the shared DRAM port.
//   Modports:
//     slave  - the arbiter view. It receives requests, write beats and memory
//              responses, and drives grants, routed beats and the DRAM command.
//     master - the environment view (engines plus DRAM controller), which is the
//              mirror of slave.
//   Parameters: NREQ requesters, AW address bits, DW data bits, LW burst-length bits.
interface mem_port_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 27,
  parameter int unsigned DW   = 32,
  parameter int unsigned LW   = 8
);
  // requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_wvalid;
  logic [NREQ-1:0]    req_wready;
  logic [DW-1:0]      rsp_rdata;
  logic [NREQ-1:0]    rsp_rvalid;
  logic [NREQ-1:0]    req_done;
  // memory side
  logic               mem_cmd_valid;
  logic               mem_cmd_ready;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [LW-1:0]      mem_len;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wvalid;
  logic               mem_wlast;
  logic               mem_wready;
  logic [DW-1:0]      mem_rdata;
  logic               mem_rvalid;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, req_wvalid,
           mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
    output req_ready, req_wready, rsp_rdata, rsp_rvalid, req_done,
           mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid, mem_wlast
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, req_wvalid,
           mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
    input  req_ready, req_wready, rsp_rdata, rsp_rvalid, req_done,
           mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid, mem_wlast
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single external DRAM port among the FC (0), CV (1) and MP (2)
//   engines. The arbiter grants one whole burst at a time. It latches the
//   winner's command, issues it, routes the read or write beats of the granted
//   engine, pulses req_done, and then re-arbitrates.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     bus         mem_port_arbiter_if.slave. This carries the requester
//                 handshakes (req_*, rsp_*) and the DRAM command, write and
//                 read channels (mem_*).
//   Build option:
//     MEM_ARB_FIXED_PRIO_EN defined selects fixed priority, where the lowest
//     index wins. When it is undefined, the build uses round-robin, with the
//     search starting after the last grant.
module mem_port_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 27,
  parameter int unsigned DW   = 32,
  parameter int unsigned LW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [GW-1:0] last_q, last_d;
`endif

  logic            found;
  logic [GW-1:0]   win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [LW-1:0]   win_len;
  logic [NREQ-1:0] gnt_oh;
  logic            sel_wvalid;
  logic [DW-1:0]   sel_wdata;

  // Arbitration: pick a winner among req_valid and capture its command fields.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_we   = 1'b0;
    win_addr = '0;
    win_len  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found    = 1'b1;
        win      = GW'(i);
        win_we   = bus.req_we[i];
        win_addr = bus.req_addr[i*AW +: AW];
        win_len  = bus.req_len[i*LW +: LW];
      end
    end
`else
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned c;
      c = (32'(last_q) + k) % NREQ;
      if (!found && bus.req_valid[c]) begin
        found    = 1'b1;
        win      = GW'(c);
        win_we   = bus.req_we[c];
        win_addr = bus.req_addr[c*AW +: AW];
        win_len  = bus.req_len[c*LW +: LW];
      end
    end
`endif
  end

  // The granted requester is held as a one-hot vector. This lets the outputs
  // be masked without a variable index, so a non-granted requester never sees
  // anything.
  always_comb begin
    gnt_oh     = '0;
    sel_wvalid = 1'b0;
    sel_wdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q == GW'(i)) begin
        gnt_oh[i]  = 1'b1;
        sel_wvalid = bus.req_wvalid[i];
        sel_wdata  = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    bus.req_ready     = '0;
    bus.req_wready    = '0;
    bus.rsp_rvalid    = '0;
    bus.rsp_rdata     = '0;
    bus.req_done      = '0;
    bus.mem_cmd_valid = 1'b0;
    bus.mem_wdata     = '0;
    bus.mem_wvalid    = 1'b0;
    bus.mem_wlast     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = win;
          we_d    = win_we;
          addr_d  = win_addr;
          len_d   = win_len;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        if (bus.mem_cmd_ready) begin
          bus.req_ready = gnt_oh;
          cnt_d         = len_q;
          state_d       = we_q ? S_WR : S_RD;
        end
      end
      S_RD: begin
        bus.rsp_rvalid = gnt_oh & {NREQ{bus.mem_rvalid}};
        bus.rsp_rdata  = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - LW'(1);
        end
      end
      S_WR: begin
        bus.mem_wvalid = sel_wvalid;
        bus.mem_wdata  = sel_wdata;
        bus.req_wready = gnt_oh & {NREQ{bus.mem_wready}};
        bus.mem_wlast  = (cnt_q == '0);
        if (sel_wvalid && bus.mem_wready) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - LW'(1);
        end
      end
      S_DONE: begin
        bus.req_done = gnt_oh;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d       = gnt_q;
`endif
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_len  = len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q  <= GW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 27;
  localparam int unsigned DW   = 32;
  localparam int unsigned LW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) bus ();

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } burst_t;

  burst_t eq[NREQ][$];   // pending bursts per engine; the head is presented on req_*

  int unsigned p_cmd = 100, p_rv = 100, p_wr = 100, p_wv = 100;
  bit want_rst = 1'b1;

  int nvec = 0, nfail = 0, cyc = 0;

  // reference model: one burst in flight, tracked by beats remaining
  bit            m_busy, m_cmd, m_done;
  int            m_g, m_left, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;

  // observation counters
  int cnt_rv[NREQ], cnt_done[NREQ], cnt_wrdy[NREQ];
  int wfire, wlast_fire, wv_nolast;
  int glog[$];
  bit seen_cmd, seen_req;
  int cmd_cyc, req_cyc, cap_addr, cap_len, cap_we;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NREQ; i++) begin
      cnt_rv[i] = 0; cnt_done[i] = 0; cnt_wrdy[i] = 0;
    end
    wfire = 0; wlast_fire = 0; wv_nolast = 0;
    glog.delete();
    seen_cmd = 0; seen_req = 0;
  endtask

  task automatic push(input int i, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    burst_t b;
    b.we = we; b.addr = addr; b.len = len;
    eq[i].push_back(b);
  endtask

  task automatic drive();
    rst_n = !want_rst;
    for (int i = 0; i < NREQ; i++) begin
      if (eq[i].size() > 0) begin
        bus.req_valid[i]           = 1'b1;
        bus.req_we[i]              = eq[i][0].we;
        bus.req_addr[i*AW +: AW]   = eq[i][0].addr;
        bus.req_len[i*LW +: LW]    = eq[i][0].len;
      end else begin
        bus.req_valid[i]           = 1'b0;
        bus.req_we[i]              = 1'($urandom_range(1));
        bus.req_addr[i*AW +: AW]   = AW'($urandom());
        bus.req_len[i*LW +: LW]    = LW'($urandom());
      end
      bus.req_wvalid[i]          = ($urandom_range(99) < p_wv);
      bus.req_wdata[i*DW +: DW]  = $urandom();
    end
    bus.mem_cmd_ready = ($urandom_range(99) < p_cmd);
    bus.mem_wready    = ($urandom_range(99) < p_wr);
    bus.mem_rvalid    = ($urandom_range(99) < p_rv);
    bus.mem_rdata     = $urandom();
  endtask

  // expected outputs from the burst-level model and the current inputs
  task automatic check_cycle();
    logic [NREQ-1:0] e_rdy, e_wrdy, e_rv, e_done;
    logic e_cv, e_wv, e_wl;
    logic [4*NREQ+2:0] got, exp;
    e_rdy = '0; e_wrdy = '0; e_rv = '0; e_done = '0;
    e_cv = 1'b0; e_wv = 1'b0; e_wl = 1'b0;
    if (rst_n && m_busy) begin
      if (m_done)       e_done[m_g] = 1'b1;
      else if (m_cmd) begin
        e_cv = 1'b1;
        e_rdy[m_g] = bus.mem_cmd_ready;
      end else if (!m_we) e_rv[m_g] = bus.mem_rvalid;
      else begin
        e_wv = bus.req_wvalid[m_g];
        e_wrdy[m_g] = bus.mem_wready;
        e_wl = (m_left == 1);
      end
    end
    got = {bus.req_ready, bus.req_wready, bus.rsp_rvalid, bus.req_done,
           bus.mem_cmd_valid, bus.mem_wvalid, bus.mem_wlast};
    exp = {e_rdy, e_wrdy, e_rv, e_done, e_cv, e_wv, e_wl};
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL ctrl cyc=%0d got=%h expected=%h", cyc, got, exp);
    end
    if (e_cv) begin
      nvec++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_len} !== {m_we, m_addr, m_len}) begin
        nfail++;
        $display("FAIL cmd_fields cyc=%0d got=%0d/%h/%0d expected=%0d/%h/%0d", cyc,
                 bus.mem_we, bus.mem_addr, bus.mem_len, m_we, m_addr, m_len);
      end
    end
    if (|e_rv) begin
      nvec++;
      if (bus.rsp_rdata !== bus.mem_rdata) begin
        nfail++;
        $display("FAIL rdata cyc=%0d got=%h expected=%h", cyc, bus.rsp_rdata, bus.mem_rdata);
      end
    end
    if (e_wv) begin
      nvec++;
      if (bus.mem_wdata !== bus.req_wdata[m_g*DW +: DW]) begin
        nfail++;
        $display("FAIL wdata cyc=%0d got=%h expected=%h", cyc, bus.mem_wdata, bus.req_wdata[m_g*DW +: DW]);
      end
    end
    if (!rst_n) begin
      nvec++;
      if ({bus.rsp_rdata, bus.mem_wdata, bus.mem_we, bus.mem_addr, bus.mem_len} !== '0) begin
        nfail++;
        $display("FAIL reset_data cyc=%0d got nonzero expected 0", cyc);
      end
    end
  endtask

  task automatic observe();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.rsp_rvalid[i]) cnt_rv[i]++;
      if (bus.req_done[i])   cnt_done[i]++;
      if (bus.req_wready[i]) cnt_wrdy[i]++;
      if (bus.req_ready[i]) begin
        glog.push_back(i);
        if (eq[i].size() > 0) eq[i].delete(0);
      end
    end
    if (bus.mem_wvalid && bus.mem_wready) wfire++;
    if (bus.mem_wvalid && bus.mem_wready && bus.mem_wlast) wlast_fire++;
    if (bus.mem_wvalid && !bus.mem_wlast) wv_nolast++;
    if (bus.mem_cmd_valid && !seen_cmd) begin
      seen_cmd = 1; cmd_cyc = cyc;
      cap_addr = int'(bus.mem_addr); cap_len = int'(bus.mem_len); cap_we = int'(bus.mem_we);
    end
    if (bus.req_valid[0] && !seen_req) begin
      seen_req = 1; req_cyc = cyc;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_busy = 0; m_cmd = 0; m_done = 0; m_last = NREQ - 1;
    end else if (!m_busy) begin
      int w;
      w = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = NREQ - 1; i >= 0; i--) if (bus.req_valid[i]) w = i;
`else
      for (int k = NREQ; k >= 1; k--) if (bus.req_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
      if (w >= 0) begin
        m_busy = 1; m_cmd = 1; m_g = w;
        m_we = bus.req_we[w]; m_addr = bus.req_addr[w*AW +: AW]; m_len = bus.req_len[w*LW +: LW];
      end
    end else if (m_done) begin
      m_last = m_g; m_busy = 0; m_done = 0;
    end else if (m_cmd) begin
      if (bus.mem_cmd_ready) begin
        m_cmd = 0; m_left = int'(m_len) + 1;
      end
    end else begin
      if (m_we ? (bus.req_wvalid[m_g] && bus.mem_wready) : bus.mem_rvalid) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_cycle();
    observe();
    model_step();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic bit pending();
    bit p;
    p = m_busy;
    for (int i = 0; i < NREQ; i++) if (eq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    if (pending()) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int exp_order[4];
    m_busy = 0; m_cmd = 0; m_done = 0; m_last = NREQ - 1;
    clear_obs();

    // reset: all outputs held at zero
    want_rst = 1;
    run(3);
    want_rst = 0;
    run(2);

    // all three requesters at once, each burst two beats
    clear_obs();
    p_cmd = 100; p_rv = 100; p_wv = 100; p_wr = 100;
    for (int i = 0; i < 3; i++) push(0, 1'b0, AW'(32'h40 * i), 8'd1);
    push(1, 1'b0, 27'h1000, 8'd1);
    push(2, 1'b0, 27'h2000, 8'd1);
    run_until_idle("t3", 200);
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 1};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    check("t3_ngrants", (glog.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), (glog.size() > i) ? glog[i] : -1, exp_order[i]);

    // FC read len=3 with mem_rvalid stuck high, including the idle and command cycles
    clear_obs();
    p_cmd = 100; p_rv = 100;
    push(0, 1'b0, 27'h100, 8'd3);
    run_until_idle("t1", 50);
    check("t1_latency", cmd_cyc - req_cyc, 1);
    check("t1_addr", cap_addr, 'h100);
    check("t1_len", cap_len, 3);
    check("t1_we", cap_we, 0);
    check("t1_beats", cnt_rv[0], 4);
    check("t1_done", cnt_done[0], 1);

    // CV single-beat write with mem_wready withheld
    clear_obs();
    p_cmd = 100; p_wr = 0; p_wv = 100; p_rv = 50;
    push(1, 1'b1, 27'h200, 8'd0);
    run(4);
    p_wr = 100;
    run_until_idle("t2", 50);
    check("t2_wready", cnt_wrdy[1], 1);
    check("t2_wlast_fire", wlast_fire, 1);
    check("t2_wv_nolast", wv_nolast, 0);
    check("t2_done", cnt_done[1], 1);

    // maximum-length read
    clear_obs();
    p_cmd = 70; p_rv = 60;
    push(2, 1'b0, 27'h7ff0000, 8'd255);
    run_until_idle("t4", 2000);
    p_rv = 100;
    run(10);
    check("t4_beats", cnt_rv[2], 256);
    check("t4_done", cnt_done[2], 1);

    // reset during the third write beat; a pending MP read follows cleanly
    clear_obs();
    p_cmd = 100; p_wr = 100; p_wv = 100; p_rv = 100;
    push(1, 1'b1, 27'h300, 8'd7);
    push(2, 1'b0, 27'h400, 8'd2);
    for (int n = 0; n < 40 && wfire < 2; n++) cycle();
    check("t5_fires_before_rst", wfire, 2);
    want_rst = 1;
    run(2);
    want_rst = 0;
    glog.delete();
    run_until_idle("t5", 100);
    check("t5_grant", (glog.size() > 0) ? glog[0] : -1, 2);
    check("t5_done2", cnt_done[2], 1);
    check("t5_done1", cnt_done[1], 0);
    check("t5_beats2", cnt_rv[2], 3);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) begin
        p_cmd = $urandom_range(100, 20); p_rv = $urandom_range(100, 20);
        p_wr  = $urandom_range(100, 20); p_wv = $urandom_range(100, 20);
      end
      if ($urandom_range(7) == 0) begin
        int i;
        i = $urandom_range(NREQ - 1);
        if (eq[i].size() < 3)
          push(i, 1'($urandom_range(1)), AW'($urandom()),
               ($urandom_range(9) == 0) ? LW'($urandom_range(40)) : LW'($urandom_range(7)));
      end
      cycle();
    end
    run_until_idle("rand", 8000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
